// File: rtl/meta_tag_array_pkg.sv
// Shared defaults, flush FSM encoding and width helper for the meta tag array.
package meta_tag_array_pkg;

    localparam int DEF_SETS  = 32;
    localparam int DEF_WAYS  = 2;
    localparam int DEF_TAG_W = 9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    // ceil(log2(n)), never less than 1 so index ports always exist
    function automatic int clog2m1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/meta_tag_set.sv
// One set of the tag array: entries, LRU ages, tag compare and victim choice.
module meta_tag_set
    import meta_tag_array_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int TAG_W = DEF_TAG_W,
    localparam int WW   = clog2m1(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             lk_en_i,
    input  logic [TAG_W-1:0] lk_tag_i,
    input  logic             fill_en_i,
    input  logic [WW-1:0]    fill_way_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic             inv_en_i,
    input  logic [TAG_W-1:0] inv_tag_i,
    output logic             hit_o,
    output logic [WW-1:0]    hit_way_o,
    output logic [WW-1:0]    victim_way_o
);

    typedef logic [WAYS-1:0][WW-1:0] age_t;

    logic [WAYS-1:0]            vld_q, vld_d;
    logic [WAYS-1:0][TAG_W-1:0] tag_q, tag_d;
    age_t                       age_q, age_d;
    logic [WAYS-1:0]            lk_match, inv_match;

    // Make 'sel' MRU; every way younger than it slides one step older.
    function automatic age_t promote(input age_t a, input logic [WW-1:0] sel);
        age_t          r;
        logic [WW-1:0] sa;
        r  = a;
        sa = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (WW'(w) == sel) sa = a[w];
        end
        for (int w = 0; w < WAYS; w++) begin
            if (WW'(w) == sel)   r[w] = '0;
            else if (a[w] < sa)  r[w] = a[w] + 1'b1;
        end
        return r;
    endfunction

    // Tag compare against lookup and invalidate keys
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            lk_match[w]  = vld_q[w] && (tag_q[w] == lk_tag_i);
            inv_match[w] = vld_q[w] && (tag_q[w] == inv_tag_i);
        end
    end

    // Lowest-index hit; victim is lowest invalid way, else the LRU way
    always_comb begin
        hit_o        = |lk_match;
        hit_way_o    = '0;
        victim_way_o = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_match[w]) hit_way_o = WW'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[w] == WW'(WAYS - 1)) victim_way_o = WW'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vld_q[w]) victim_way_o = WW'(w);
        end
    end

    // Next state: flush clear beats everything; fill beats invalidate and lookup aging
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        age_d = age_q;
        if (clr_i) begin
            vld_d = '0;
            for (int w = 0; w < WAYS; w++) age_d[w] = WW'(w);
        end else begin
            if (inv_en_i) vld_d = vld_q & ~inv_match;
            if (fill_en_i) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WW'(w) == fill_way_i) begin
                        vld_d[w] = 1'b1;
                        tag_d[w] = fill_tag_i;
                    end
                end
                age_d = promote(age_q, fill_way_i);
            end else if (lk_en_i && hit_o) begin
                age_d = promote(age_q, hit_way_o);
            end
        end
    end

    // Entry and age storage; reset leaves ages as the identity permutation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            tag_q <= '0;
            for (int w = 0; w < WAYS; w++) age_q[w] <= WW'(w);
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/meta_tag_array.sv
// Set-associative tag array with per-set LRU, registered lookup and sweeping flush.
module meta_tag_array
    import meta_tag_array_pkg::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int WAYS  = DEF_WAYS,
    parameter int TAG_W = DEF_TAG_W,
    localparam int SW   = clog2m1(SETS),
    localparam int WW   = clog2m1(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk_en,
    input  logic [SW-1:0]    lk_set,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             hit,
    output logic [WW-1:0]    hit_way,
    output logic [WW-1:0]    victim_way,
    output logic             rsp_vld,
    input  logic             fill_en,
    input  logic [SW-1:0]    fill_set,
    input  logic [WW-1:0]    fill_way,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             inv_en,
    input  logic [SW-1:0]    inv_set,
    input  logic [TAG_W-1:0] inv_tag,
    input  logic             flush_req,
    output logic             busy,
    output logic             flush_done
);

    flush_state_e     state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             busy_w;

    logic [SETS-1:0]          set_hit;
    logic [SETS-1:0][WW-1:0]  set_hit_way;
    logic [SETS-1:0][WW-1:0]  set_victim;

    logic             rsp_vld_q, hit_q;
    logic [WW-1:0]    hit_way_q, victim_q;

    // Flush FSM state, set counter and completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Flush FSM next state: sweep one set per cycle, leave after the last one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(SETS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flush FSM outputs
    always_comb begin
        busy_w = (state_q == ST_FLUSH);
    end

    // One set instance per index; requests are steered and masked while flushing
    for (genvar s = 0; s < SETS; s++) begin : g_set
        meta_tag_set #(
            .WAYS  (WAYS),
            .TAG_W (TAG_W)
        ) u_set (
            .clk          (clk),
            .rst          (rst),
            .clr_i        (busy_w && (cnt_q == SW'(s))),
            .lk_en_i      (lk_en && !busy_w && (lk_set == SW'(s))),
            .lk_tag_i     (lk_tag),
            .fill_en_i    (fill_en && !busy_w && (fill_set == SW'(s))),
            .fill_way_i   (fill_way),
            .fill_tag_i   (fill_tag),
            .inv_en_i     (inv_en && !busy_w && (inv_set == SW'(s))),
            .inv_tag_i    (inv_tag),
            .hit_o        (set_hit[s]),
            .hit_way_o    (set_hit_way[s]),
            .victim_way_o (set_victim[s])
        );
    end

    // Registered lookup response from pre-write state; a lookup during flush always misses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld_q <= 1'b0;
            hit_q     <= 1'b0;
            hit_way_q <= '0;
            victim_q  <= '0;
        end else begin
            rsp_vld_q <= lk_en;
            hit_q     <= lk_en && !busy_w && set_hit[lk_set];
            if (lk_en) begin
                hit_way_q <= busy_w ? '0 : set_hit_way[lk_set];
                victim_q  <= set_victim[lk_set];
            end
        end
    end

    assign rsp_vld    = rsp_vld_q;
    assign hit        = hit_q;
    assign hit_way    = hit_way_q;
    assign victim_way = victim_q;
    assign busy       = busy_w;
    assign flush_done = done_q;

endmodule

// File: tb/tb_meta_tag_array.sv
// Scoreboarded random + directed bench for meta_tag_array against an LRU-list model.
module tb_meta_tag_array;

    localparam int SETS  = 32;
    localparam int WAYS  = 2;
    localparam int TAG_W = 9;
    localparam int SW    = 5;
    localparam int WW    = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             lk_en, fill_en, inv_en, flush_req;
    logic [SW-1:0]    lk_set, fill_set, inv_set;
    logic [TAG_W-1:0] lk_tag, fill_tag, inv_tag;
    logic [WW-1:0]    fill_way;
    logic             hit, rsp_vld, busy, flush_done;
    logic [WW-1:0]    hit_way, victim_way;

    meta_tag_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .lk_en(lk_en), .lk_set(lk_set), .lk_tag(lk_tag),
        .hit(hit), .hit_way(hit_way), .victim_way(victim_way), .rsp_vld(rsp_vld),
        .fill_en(fill_en), .fill_set(fill_set), .fill_way(fill_way), .fill_tag(fill_tag),
        .inv_en(inv_en), .inv_set(inv_set), .inv_tag(inv_tag),
        .flush_req(flush_req), .busy(busy), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hit;
        int hway;
        int victim;
        bit chkv;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model: valid/tag per entry plus a recency list per set (front = MRU, back = LRU)
    bit   mvld[SETS][WAYS];
    int   mtag[SETS][WAYS];
    int   mord[SETS][$];
    bit   mbusy = 1'b0;
    int   pool[4] = '{'h055, 'h02A, 'h011, 'h1FF};

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            mord[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                mvld[s][w] = 1'b0;
                mtag[s][w] = 0;
                mord[s].push_back(w);
            end
        end
    endtask

    task automatic m_touch(input int s, input int w);
        int idx = 0;
        for (int i = 0; i < mord[s].size(); i++) if (mord[s][i] == w) idx = i;
        mord[s].delete(idx);
        mord[s].push_front(w);
    endtask

    // One clock of stimulus: drive, predict, advance to the following negedge
    task automatic cycle(input bit l, input int ls, input int lt,
                         input bit f, input int fs, input int fw, input int ft,
                         input bit iv, input int is, input int it, input bit fr);
        exp_t e;
        bit   hv;
        int   hw;
        lk_en = l;    lk_set = SW'(ls);   lk_tag = TAG_W'(lt);
        fill_en = f;  fill_set = SW'(fs); fill_way = WW'(fw); fill_tag = TAG_W'(ft);
        inv_en = iv;  inv_set = SW'(is);  inv_tag = TAG_W'(it);
        flush_req = fr;
        hv = 1'b0;
        hw = 0;
        if (l) begin
            for (int w = WAYS - 1; w >= 0; w--)
                if (mvld[ls][w] && mtag[ls][w] == lt) begin hv = 1'b1; hw = w; end
            e.hit    = (hv && !mbusy) ? 1 : 0;
            e.hway   = hw;
            e.chkv   = !mbusy;
            e.victim = mord[ls][WAYS-1];
            for (int w = WAYS - 1; w >= 0; w--) if (!mvld[ls][w]) e.victim = w;
            sbq.push_back(e);
        end
        if (!mbusy) begin
            if (iv) for (int w = 0; w < WAYS; w++)
                if (mvld[is][w] && mtag[is][w] == it) mvld[is][w] = 1'b0;
            if (f) begin
                mvld[fs][fw] = 1'b1;
                mtag[fs][fw] = ft;
                m_touch(fs, fw);
            end
            if (l && hv && !(f && fs == ls)) m_touch(ls, hw);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        if (l) begin
            n_chk++;
            if (sbq.size() != 0) begin
                n_fail++;
                $display("FAIL rsp_latency: %0d responses outstanding, required 0", sbq.size());
                sbq.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic lookup(input int s, input int t);
        cycle(1, s, t, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic fill(input int s, input int w, input int t);
        cycle(0, 0, 0, 1, s, w, t, 0, 0, 0, 0);
    endtask
    task automatic inval(input int s, input int t);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, s, t, 0);
    endtask

    // Monitor: every presented response is matched against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && rsp_vld === 1'b1) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_vld=1 with no lookup outstanding");
            end else begin
                e = sbq.pop_front();
                check("hit", int'(hit), e.hit);
                if (e.hit != 0) check("hit_way", int'(hit_way), e.hway);
                if (e.chkv) check("victim_way", int'(victim_way), e.victim);
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_hit"},        int'(hit),        0);
        check({tag, "_hit_way"},    int'(hit_way),    0);
        check({tag, "_victim_way"}, int'(victim_way), 0);
        check({tag, "_rsp_vld"},    int'(rsp_vld),    0);
        check({tag, "_busy"},       int'(busy),       0);
        check({tag, "_flush_done"}, int'(flush_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ls, lt, fs, fw, ft, is, it;
        bit l, f, iv;
        rst = 1'b0;
        lk_en = 0; lk_set = '0; lk_tag = '0;
        fill_en = 0; fill_set = '0; fill_way = '0; fill_tag = '0;
        inv_en = 0; inv_set = '0; inv_tag = '0; flush_req = 0;
        m_reset();
        #1;
        check_quiet("in_reset");
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_quiet("after_reset");
        @(negedge clk);
        #1;

        // Empty array: miss, victim way 0
        lookup(3, 'h55);
        // Hit on way 0, then way 1 becomes LRU victim
        fill(3, 0, 'h55);
        fill(3, 1, 'h2A);
        lookup(3, 'h55);
        lookup(3, 'h11);
        // Same-cycle fill and lookup hit in one set: fill owns the age update
        fill(5, 0, 'h33);
        cycle(1, 5, 'h33, 1, 5, 1, 'h44, 0, 0, 0, 0);
        lookup(5, 'h99);
        // Invalidate present and absent tags
        inval(3, 'h55);
        lookup(3, 'h55);
        inval(3, 'h77);
        lookup(3, 'h2A);
        // Fill and invalidate on the same way: fill wins
        fill(6, 1, 'h10);
        cycle(0, 0, 0, 1, 6, 1, 'h20, 1, 6, 'h10, 0);
        lookup(6, 'h20);

        // Random traffic concentrated on a few sets to produce hits and evictions
        for (int n = 0; n < 500; n++) begin
            l  = ($urandom_range(0, 9) < 6);
            ls = $urandom_range(0, 3);
            lt = pool[$urandom_range(0, 3)];
            f  = ($urandom_range(0, 9) < 3);
            fs = $urandom_range(0, 3);
            fw = $urandom_range(0, WAYS - 1);
            ft = pool[$urandom_range(0, 3)];
            for (int w = 0; w < WAYS; w++)
                if (w != fw && mvld[fs][w] && mtag[fs][w] == ft) fw = w;
            iv = ($urandom_range(0, 9) < 2);
            is = $urandom_range(0, 3);
            it = pool[$urandom_range(0, 3)];
            cycle(l, ls, lt, f, fs, fw, ft, iv, is, it, 0);
        end

        // Full flush: busy for SETS cycles, single done pulse, traffic ignored meanwhile
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        mbusy = 1'b1;
        for (int k = 1; k <= SETS; k++) begin
            check("flush_busy", int'(busy), 1);
            check("flush_done_early", int'(flush_done), 0);
            if (k == 5)       cycle(1, 1, pool[0], 1, 0, 0, 'h55, 0, 0, 0, 0);
            else if (k == 10) cycle(1, 2, pool[1], 0, 0, 0, 0, 1, 2, pool[1], 1);
            else if (k % 4 == 0) lookup($urandom_range(0, 3), pool[$urandom_range(0, 3)]);
            else idle(1);
        end
        mbusy = 1'b0;
        m_reset();
        check("flush_end_busy", int'(busy), 0);
        check("flush_done_pulse", int'(flush_done), 1);
        idle(1);
        check("flush_done_single", int'(flush_done), 0);
        check("flush_end_busy2", int'(busy), 0);
        for (int s = 0; s < SETS; s++) lookup(s, pool[s % 4]);
        lookup(0, 'h55);

        // Reset in the middle of a flush
        fill(10, 0, 'h55);
        fill(20, 1, 'h2A);
        fill(2, 0, 'h11);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        mbusy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            check("abort_busy", int'(busy), 1);
            idle(1);
        end
        rst = 1'b0;
        #1;
        check_quiet("mid_flush_reset");
        m_reset();
        mbusy = 1'b0;
        #1 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("abort_no_done", int'(flush_done), 0);
            check("abort_not_busy", int'(busy), 0);
            idle(1);
        end
        lookup(10, 'h55);
        lookup(20, 'h2A);
        lookup(2, 'h11);
        lookup(3, 'h2A);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
